// File: rtl/axi_burst_sink.sv
// AXI3-style write responder: one burst at a time into internal memory, B response, side read port.
// Optional macro AXI_SINK_STALL_EN: wready alternates in DATA and the B response gains one cycle.
module axi_burst_sink #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    MEM_DEPTH  = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 64'h43C1_0000
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic [1:0]                     awburst_i,
    input  logic [ADDR_WIDTH-1:0]          awaddr_i,
    input  logic                           awvalid_i,
    output logic                           awready_o,
    input  logic [3:0]                     wid_i,
    input  logic [DATA_WIDTH-1:0]          wdata_i,
    input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
    input  logic                           wlast_i,
    input  logic                           wvalid_i,
    output logic                           wready_o,
    output logic [3:0]                     bid_o,
    output logic [1:0]                     bresp_o,
    output logic                           bvalid_o,
    input  logic                           bready_i,
    input  logic                           rd_en_i,
    input  logic [$clog2(MEM_DEPTH)-1:0]   rd_idx_i,
    output logic [DATA_WIDTH-1:0]          rd_data_o,
    output logic [31:0]                    beat_cnt_o,
    output logic [31:0]                    burst_cnt_o
);

    localparam int                    STRB_W   = DATA_WIDTH / 8;
    localparam int                    IDX_W    = $clog2(MEM_DEPTH);
    localparam int                    BYTE_SH  = $clog2(STRB_W);
    localparam logic [ADDR_WIDTH-1:0] WINDOW   = ADDR_WIDTH'(MEM_DEPTH * STRB_W);
    localparam logic [ADDR_WIDTH-1:0] BEAT_INC = ADDR_WIDTH'(STRB_W);

`ifdef AXI_SINK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, GAP, RESP} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]        wr_idx;
    logic                    in_range, wr_en;
    logic                    aw_fire, w_fire, b_fire;
    logic                    incr, drop, err, first, phase;
    logic [3:0]              bid;
    logic [31:0]             beat_cnt, burst_cnt;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    always_comb begin
        state_nxt = state;
        awready_o = 1'b0;
        wready_o  = 1'b0;
        bvalid_o  = 1'b0;
        case (state)
            IDLE: begin
                awready_o = 1'b1;
                if (awvalid_i) state_nxt = DATA;
            end
            DATA: begin
                wready_o = STALL ? phase : 1'b1;
                if (wvalid_i && wready_o && wlast_i) state_nxt = STALL ? GAP : RESP;
            end
            GAP:  state_nxt = RESP;
            RESP: begin
                bvalid_o = 1'b1;
                if (bready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign aw_fire  = awvalid_i & awready_o;
    assign w_fire   = wvalid_i & wready_o;
    assign b_fire   = bvalid_o & bready_i;
    // Range is checked per beat, so an INCR burst can run off the end of the window mid-burst.
    assign offset   = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (offset < WINDOW);
    assign wr_idx   = offset[BYTE_SH +: IDX_W];
    assign wr_en    = w_fire & ~drop & in_range & ~areset;

    always_ff @(posedge clk) begin
        if (areset) begin
            state     <= IDLE;
            incr      <= 1'b0;
            drop      <= 1'b0;
            err       <= 1'b0;
            first     <= 1'b0;
            phase     <= 1'b0;
            bid       <= 4'd0;
            beat_cnt  <= 32'd0;
            burst_cnt <= 32'd0;
            rd_data   <= '0;
        end else begin
            state <= state_nxt;
            if (aw_fire) begin
                incr  <= (awburst_i == 2'b01);
                drop  <= awburst_i[1];
                err   <= 1'b0;
                first <= 1'b1;
                phase <= 1'b0;
            end
            if (state == DATA) phase <= ~phase;
            if (w_fire) begin
                beat_cnt <= beat_cnt + 32'd1;
                first    <= 1'b0;
                if (first) bid <= wid_i;
                if (drop || !in_range) err <= 1'b1;
            end
            if (b_fire) burst_cnt <= burst_cnt + 32'd1;
            // Nonblocking read against the same-edge write gives read-first behaviour.
            if (rd_en_i) rd_data <= mem[rd_idx_i];
        end
    end

    always_ff @(posedge clk) begin
        if (aw_fire) addr <= awaddr_i;
        else if (w_fire && incr) addr <= addr + BEAT_INC;
        if (wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_i[b]) mem[wr_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign bid_o       = bid;
    assign bresp_o     = {err, 1'b0};
    assign rd_data_o   = rd_data;
    assign beat_cnt_o  = beat_cnt;
    assign burst_cnt_o = burst_cnt;

endmodule

// File: tb/tb_axi_burst_sink.sv
// Randomized bench for axi_burst_sink with a transaction-level reference model and per-cycle compare.
module tb_axi_burst_sink;

    localparam int          DEPTH = 256;
    localparam logic [63:0] BASE  = 64'h43C1_0000;
    localparam logic [63:0] WIN   = 64'd1024;
`ifdef AXI_SINK_STALL_EN
    localparam bit STALL = 1'b1;
`else
    localparam bit STALL = 1'b0;
`endif
    localparam int P_IDLE = 0, P_DATA = 1, P_GAP = 2, P_RESP = 3;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [1:0]  awburst = 2'b00;
    logic [63:0] awaddr = '0;
    logic        awvalid = 1'b0, awready;
    logic [3:0]  wid = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0, wvalid = 1'b0, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready = 1'b0;
    logic        rd_en = 1'b0;
    logic [7:0]  rd_idx = '0;
    logic [31:0] rd_data, beat_cnt, burst_cnt;

    axi_burst_sink dut (
        .clk(clk), .areset(areset),
        .awburst_i(awburst), .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
        .wid_i(wid), .wdata_i(wdata), .wstrb_i(wstrb), .wlast_i(wlast),
        .wvalid_i(wvalid), .wready_o(wready),
        .bid_o(bid), .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
        .rd_en_i(rd_en), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .beat_cnt_o(beat_cnt), .burst_cnt_o(burst_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: memory image, counters and the current transaction phase.
    logic [31:0] m_mem [DEPTH];
    int          m_phase = P_IDLE;
    int          m_k = 0;
    int          m_acc = 0;
    logic [63:0] m_addr = '0;
    logic [1:0]  m_bt = '0;
    bit          m_err = 1'b0, m_first = 1'b0;
    logic [3:0]  m_bid = '0;
    logic [31:0] m_beat = '0, m_burst = '0, m_rd = '0;

    always @(posedge clk) begin
        if (areset) begin
            m_phase = P_IDLE;
            m_beat  = '0;
            m_burst = '0;
            m_rd    = '0;
            m_bid   = '0;
            m_err   = 1'b0;
        end else begin
            if (rd_en) m_rd = m_mem[rd_idx];
            case (m_phase)
                P_IDLE: if (awvalid) begin
                    m_phase = P_DATA; m_addr = awaddr; m_bt = awburst;
                    m_err = 1'b0; m_first = 1'b1; m_k = 0;
                end
                P_DATA: begin
                    if (wvalid && (!STALL || (m_k % 2) == 1)) begin
                        m_acc++;
                        m_beat = m_beat + 32'd1;
                        if (m_first) begin m_bid = wid; m_first = 1'b0; end
                        if (m_bt[1]) m_err = 1'b1;
                        else if (m_addr >= BASE && m_addr < BASE + WIN) begin
                            for (int b = 0; b < 4; b++)
                                if (wstrb[b]) m_mem[int'((m_addr - BASE) >> 2)][8*b +: 8] = wdata[8*b +: 8];
                        end else m_err = 1'b1;
                        if (m_bt == 2'b01) m_addr = m_addr + 64'd4;
                        if (wlast) m_phase = STALL ? P_GAP : P_RESP;
                    end
                    m_k++;
                end
                P_GAP:  m_phase = P_RESP;
                default: if (bready) begin m_burst = m_burst + 32'd1; m_phase = P_IDLE; end
            endcase
        end
    end

    int  n_checks = 0, n_errors = 0;
    bit  rnd_rd = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("awready", 64'(awready), 64'(m_phase == P_IDLE));
        chk("wready", 64'(wready), 64'(m_phase == P_DATA && (!STALL || (m_k % 2) == 1)));
        chk("bvalid", 64'(bvalid), 64'(m_phase == P_RESP));
        if (m_phase == P_RESP) begin
            chk("bresp", 64'(bresp), m_err ? 64'd2 : 64'd0);
            chk("bid", 64'(bid), 64'(m_bid));
        end
        chk("beat_cnt", 64'(beat_cnt), 64'(m_beat));
        chk("burst_cnt", 64'(burst_cnt), 64'(m_burst));
        chk("rd_data", 64'(rd_data), 64'(m_rd));
    endtask

    task automatic send_aw(input logic [1:0] bt, input logic [63:0] a);
        awvalid = 1'b1; awburst = bt; awaddr = a;
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic [3:0] id,
                             input bit last, input bit gaps);
        int start;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        wvalid = 1'b1; wdata = d; wstrb = s; wid = id; wlast = last;
        start = m_acc;
        for (int i = 0; i < 40 && m_acc == start; i++) @(negedge clk);
        if (m_acc == start) chk("beat_timeout wready", 64'(wready), 64'd1);
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 20 && m_phase != P_RESP; i++) @(negedge clk);
        chk("resp_wait bvalid", 64'(bvalid), 64'd1);
    endtask

    task automatic finish_b(input int hold, input bit poke_aw);
        wait_resp();
        for (int i = 0; i < hold; i++) begin
            if (poke_aw) begin awvalid = 1'b1; awburst = 2'b01; awaddr = BASE; end
            @(negedge clk);
            if (poke_aw) begin
                chk("hold bvalid", 64'(bvalid), 64'd1);
                chk("hold awready", 64'(awready), 64'd0);
            end
        end
        awvalid = 1'b0;
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
    endtask

    task automatic rd_word(input int idx, output logic [31:0] d);
        rd_en = 1'b1; rd_idx = 8'(idx);
        @(negedge clk);
        d = rd_data;
        rd_en = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        int start, len;
        logic [1:0] bt;
        fork
            begin
                repeat (60000) @(posedge clk);
                $display("FAIL watchdog expired checks=%0d", n_checks);
                $fatal(1);
            end
        join_none
        repeat (3) @(negedge clk);
        fork
            forever @(negedge clk) compare_all();
            forever @(negedge clk) if (rnd_rd) begin
                rd_en = 1'($urandom_range(0, 1)); rd_idx = 8'($urandom_range(0, 255));
            end
        join_none
        chk("rst awready", 64'(awready), 64'd1);
        chk("rst wready", 64'(wready), 64'd0);
        chk("rst bvalid", 64'(bvalid), 64'd0);
        chk("rst bid", 64'(bid), 64'd0);
        chk("rst bresp", 64'(bresp), 64'd0);
        chk("rst rd_data", 64'(rd_data), 64'd0);
        chk("rst beat_cnt", 64'(beat_cnt), 64'd0);
        areset = 1'b0;

        // Fill the whole memory, then reset: contents must survive, counters must clear.
        send_aw(2'b01, BASE);
        for (int i = 0; i < DEPTH; i++) send_beat($urandom, 4'hF, 4'd0, i == DEPTH - 1, 1'b0);
        finish_b(0, 1'b0);
        areset = 1'b1; @(negedge clk); areset = 1'b0;
        chk("post-rst beat_cnt", 64'(beat_cnt), 64'd0);
        chk("post-rst burst_cnt", 64'(burst_cnt), 64'd0);

        send_aw(2'b01, BASE);
        for (int i = 0; i < 4; i++) send_beat(32'(4 * i), 4'hF, 4'd3, i == 3, 1'b0);
        wait_resp();
        chk("t1 bresp", 64'(bresp), 64'd0);
        chk("t1 bid", 64'(bid), 64'd3);
        chk("t1 beat_cnt", 64'(beat_cnt), 64'd4);
        finish_b(0, 1'b0);
        chk("t1 burst_cnt", 64'(burst_cnt), 64'd1);
        for (int i = 0; i < 4; i++) begin rd_word(i, d); chk("t1 mem", 64'(d), 64'(4 * i)); end

        send_aw(2'b01, BASE);
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; wid = 4'd5; wlast = 1'b1;
        rd_en = 1'b1; rd_idx = 8'd0;
        start = m_acc;
        for (int i = 0; i < 10 && m_acc == start; i++) @(negedge clk);
        chk("read_first old", 64'(rd_data), 64'd0);
        wvalid = 1'b0; wlast = 1'b0; rd_en = 1'b0;
        finish_b(0, 1'b0);
        rd_word(0, d); chk("read_first new", 64'(d), 64'h55);

        send_aw(2'b01, BASE + 64'h3FC);
        send_beat(32'hAA, 4'hF, 4'd1, 1'b0, 1'b0);
        send_beat(32'hBB, 4'hF, 4'd1, 1'b1, 1'b0);
        wait_resp();
        chk("t2 bresp", 64'(bresp), 64'd2);
        finish_b(0, 1'b0);
        rd_word(255, d); chk("t2 mem255", 64'(d), 64'hAA);
        rd_word(0, d); chk("t2 mem0", 64'(d), 64'h55);

        send_aw(2'b00, BASE + 64'h10);
        for (int i = 1; i <= 3; i++) send_beat(32'(i), 4'hF, 4'd7, i == 3, 1'b0);
        wait_resp();
        chk("t3 bresp", 64'(bresp), 64'd0);
        finish_b(0, 1'b0);
        rd_word(4, d); chk("t3 fixed", 64'(d), 64'd3);
        send_aw(2'b00, BASE + 64'h10);
        send_beat(32'hFFFF_FFFF, 4'b0001, 4'd7, 1'b1, 1'b0);
        finish_b(0, 1'b0);
        rd_word(4, d); chk("t3 strb", 64'(d), 64'hFF);

        send_aw(2'b10, BASE + 64'h8);
        send_beat(32'hDEAD, 4'hF, 4'd2, 1'b0, 1'b0);
        send_beat(32'hBEEF, 4'hF, 4'd2, 1'b1, 1'b0);
        wait_resp();
        chk("t4 bresp", 64'(bresp), 64'd2);
        chk("t4 beat_cnt", 64'(beat_cnt), 64'd13);
        finish_b(5, 1'b1);
        chk("t4 burst_cnt", 64'(burst_cnt), 64'd6);
        rd_word(2, d); chk("t4 mem", 64'(d), 64'd8);

        send_aw(2'b01, BASE + 64'h40);
        send_beat(32'h1111, 4'hF, 4'd2, 1'b0, 1'b0);
        send_beat(32'h2222, 4'hF, 4'd2, 1'b0, 1'b0);
        areset = 1'b1; @(negedge clk); areset = 1'b0;
        chk("t5 awready", 64'(awready), 64'd1);
        chk("t5 bvalid", 64'(bvalid), 64'd0);
        rd_word(16, d); chk("t5 mem16", 64'(d), 64'h1111);
        rd_word(17, d); chk("t5 mem17", 64'(d), 64'h2222);
        send_aw(2'b01, BASE + 64'h40);
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + 32'(i), 4'hF, 4'd9, i == 3, 1'b0);
        wait_resp();
        chk("t5 bresp", 64'(bresp), 64'd0);
        chk("t5 bid", 64'(bid), 64'd9);
        finish_b(1, 1'b0);

        rnd_rd = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0, 1, 2, 3: bt = 2'b01;
                4, 5:       bt = 2'b00;
                6:          bt = 2'b10;
                default:    bt = 2'b11;
            endcase
            send_aw(bt, BASE - 64'd32 + 64'(4 * $urandom_range(0, 272)));
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++)
                send_beat($urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), i == len - 1, 1'b1);
            finish_b($urandom_range(0, 3), 1'b0);
        end
        rnd_rd = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) rd_word(i, d);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
